// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: four registered BCD digits advanced by count_tick (run) or adj_tick (adjust).
// Outputs update on the edge sampling a pulse (1-cycle latency); no backpressure, every pulse is consumed.
module stopwatch_counter #(
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_tick,
    input  logic       adj_tick,
    input  logic       pause_pulse,
    input  logic       clr_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       wrap
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] PAUSE = 1'b1;

    localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_MAX % 10);
    localparam logic [3:0] SEC_T = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_O = 4'(SEC_MAX % 10);

    logic [0:0] state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
    logic       wrap_q, wrap_d;
    logic       min_at_max, sec_at_max;
    logic [7:0] min_inc, sec_inc;

    // Two-digit BCD increment that wraps to 00 after {max_t,max_o}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] max_t, input logic [3:0] max_o);
        logic [7:0] r;
        if (t == max_t && o == max_o) begin
            r = 8'h00;
        end else if (o == 4'd9) begin
            r = {t + 4'd1, 4'd0};
        end else begin
            r = {t, o + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        min_at_max = (min_tens_q == MIN_T) && (min_ones_q == MIN_O);
        sec_at_max = (sec_tens_q == SEC_T) && (sec_ones_q == SEC_O);
        min_inc    = bcd_inc(min_tens_q, min_ones_q, MIN_T, MIN_O);
        sec_inc    = bcd_inc(sec_tens_q, sec_ones_q, SEC_T, SEC_O);

        state_d    = pause_pulse ? ~state_q : state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        wrap_d     = 1'b0;

        if (clr_pulse) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (adj) begin
            if (adj_tick) begin
                if (sel) begin
                    {sec_tens_d, sec_ones_d} = sec_inc;
                end else begin
                    {min_tens_d, min_ones_d} = min_inc;
                end
            end
        end else if (state_q == RUN && count_tick) begin
            // Qualified on the pre-toggle state: a tick coinciding with pause still counts.
            {sec_tens_d, sec_ones_d} = sec_inc;
            if (sec_at_max) begin
                {min_tens_d, min_ones_d} = min_inc;
                wrap_d = min_at_max;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            wrap_q     <= wrap_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign paused   = (state_q == PAUSE);
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Stopwatch core bench: directed scenarios then random pulses, checked against an integer-seconds model.
module tb_stopwatch_counter;
    localparam int MIN_MAX = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       count_tick = 1'b0, adj_tick = 1'b0, pause_pulse = 1'b0, clr_pulse = 1'b0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain minutes/seconds integers and a pause flag.
    int m_min = 0, m_sec = 0;
    bit m_pause = 1'b0, m_wrap = 1'b0;

    stopwatch_counter #(.MIN_MAX(MIN_MAX), .SEC_MAX(59)) dut (
        .clk(clk), .rst(rst), .count_tick(count_tick), .adj_tick(adj_tick),
        .pause_pulse(pause_pulse), .clr_pulse(clr_pulse), .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .paused(paused), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_digits();
        return ((m_min / 10) << 12) | ((m_min % 10) << 8) | ((m_sec / 10) << 4) | (m_sec % 10);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".digits"}, int'({min_tens, min_ones, sec_tens, sec_ones}), exp_digits());
        check({tag, ".paused"}, int'(paused), int'(m_pause));
        check({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    endtask

    task automatic model_edge(input bit ct, input bit at, input bit pp, input bit cp,
                              input bit a, input bit s);
        m_wrap = 1'b0;
        if (cp) begin
            m_min = 0;
            m_sec = 0;
        end else if (a) begin
            if (at) begin
                if (s) m_sec = (m_sec + 1) % 60;
                else   m_min = (m_min + 1) % (MIN_MAX + 1);
            end
        end else if (!m_pause && ct) begin
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min++;
                if (m_min > MIN_MAX) begin
                    m_min  = 0;
                    m_wrap = 1'b1;
                end
            end
        end
        if (pp) m_pause = !m_pause;
    endtask

    // One clock: drive inputs, take the edge, advance the model, check outputs 1 time unit later.
    task automatic step(input string tag, input bit ct, input bit at, input bit pp,
                        input bit cp, input bit a, input bit s);
        count_tick  = ct;
        adj_tick    = at;
        pause_pulse = pp;
        clr_pulse   = cp;
        adj         = a;
        sel         = s;
        @(posedge clk);
        model_edge(ct, at, pp, cp, a, s);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic adjust(input bit s, input int n);
        for (int i = 0; i < n; i++) step("adj", 0, 1, 0, 0, 1, s);
    endtask

    task automatic clear();
        step("clr", 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #12;
        check("reset.digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
        check("reset.paused", int'(paused), 0);
        check("reset.wrap", int'(wrap), 0);
        @(negedge clk);
        rst = 1'b1;

        // 61 spaced ticks -> 01:01
        for (int i = 0; i < 61; i++) begin
            step("count", 1, 0, 0, 0, 0, 0);
            idle(9);
        end
        check("t61", exp_digits(), 16'h0101);

        // Full wrap from 59:59
        clear();
        adjust(0, 59);
        adjust(1, 59);
        step("wrap_tick", 1, 0, 0, 0, 0, 0);
        check("wrap_model", int'(m_wrap), 1);
        idle(2);

        // Pause holds the count at 12:34
        clear();
        adjust(0, 12);
        adjust(1, 34);
        step("pause", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("paused_tick", 1, 0, 0, 0, 0, 0);
        step("resume", 0, 0, 1, 0, 0, 0);
        step("resumed_tick", 1, 0, 0, 0, 0, 0);
        check("t1235", exp_digits(), 16'h1235);

        // Adjust seconds 58 -> 01 with count_tick ignored; minutes wrap without wrap pulse
        clear();
        adjust(1, 58);
        for (int i = 0; i < 3; i++) begin
            step("adj_sec", 1, 1, 0, 0, 1, 1);
            step("adj_ct", 1, 0, 0, 0, 1, 1);
        end
        adjust(0, 59);
        step("adj_minwrap", 0, 1, 0, 0, 1, 0);

        // Simultaneous pulses
        clear();
        for (int i = 0; i < 9; i++) step("count", 1, 0, 0, 0, 0, 0);
        step("ct_pp", 1, 0, 1, 0, 0, 0);
        check("t0010", exp_digits(), 16'h0010);
        step("unpause", 0, 0, 1, 0, 0, 0);
        clear();
        adjust(0, 5);
        adjust(1, 5);
        step("clr_ct", 1, 0, 0, 1, 0, 0);

        // Asynchronous reset mid-cycle while paused at 33:33
        adjust(0, 33);
        adjust(1, 33);
        step("pause", 0, 0, 1, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        m_min = 0; m_sec = 0; m_pause = 1'b0; m_wrap = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        step("post_rst", 1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit a, s;
            a = ($urandom_range(0, 3) == 0);
            s = $urandom_range(0, 1) == 1;
            step("rand",
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 199) == 0,
                 a, s);
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
